chirp_phase_gen: RTL and testbench

Parametrised chirp (linear-FM) phase-word generator driving the sine ROM feeding the IIR filter pair.
Generalises the fixed free-running heartbeat/phase accumulator:
- programmable sample-strobe divider;
- start/stop frequency with clamping;
- three sweep modes;
- start/stop commands;
- done and sweep-trigger flags for debug capture.

---
 rtl/chirp_pkg.sv | 34 +++
 rtl/chirp_phase_gen_if.sv | 33 +++
 rtl/strobe_div.sv | 29 ++
 rtl/chirp_phase_gen.sv | 164 ++++++++++++++++
 tb/tb_chirp_phase_gen.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/chirp_pkg.sv
// Shared types and constants for the chirp phase generator.
// Sweep modes, FSM states, and the LFSR seed/taps used by the CHIRP_DITHER_EN build.
package chirp_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE   = 2'd0,
    MODE_REPEAT   = 2'd1,
    MODE_TRIANGLE = 2'd2
  } sweep_mode_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting towards the MSB
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // The reserved encoding 3 behaves as a single up-sweep.
  function automatic sweep_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_REPEAT;
      2'd2:    return MODE_TRIANGLE;
      default: return MODE_SINGLE;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/chirp_phase_gen_if.sv
// Configuration/command and sample bus of the chirp phase generator.
// The master drives cfg_* and cmd_*; the slave (generator) returns status and samples.
interface chirp_phase_gen_if #(
  parameter int unsigned PHASE_W = 48,
  parameter int unsigned OUT_W   = 16
);

  logic [PHASE_W-1:0] cfg_start_freq;
  logic [PHASE_W-1:0] cfg_stop_freq;
  logic [PHASE_W-1:0] cfg_rate;
  logic [1:0]         cfg_mode;
  logic               cmd_start;
  logic               cmd_stop;

  logic               busy;
  logic               phase_valid;
  logic [OUT_W-1:0]   phase_out;
  logic [PHASE_W-1:0] freq_out;
  logic               sweep_wrap;
  logic               done;
  logic               cfg_err;

  modport master (
    output cfg_start_freq, cfg_stop_freq, cfg_rate, cfg_mode, cmd_start, cmd_stop,
    input  busy, phase_valid, phase_out, freq_out, sweep_wrap, done, cfg_err
  );

  modport slave (
    input  cfg_start_freq, cfg_stop_freq, cfg_rate, cfg_mode, cmd_start, cmd_stop,
    output busy, phase_valid, phase_out, freq_out, sweep_wrap, done, cfg_err
  );

endinterface

// File: rtl/strobe_div.sv
// Sample-strobe divider: ticks when the count is zero, then reloads DIV-1.
// A synchronous reload forces a tick on the first enabled cycle after it.
module strobe_div #(
  parameter int unsigned DIV = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic reload,
  output logic tick
);

  logic [7:0] count;

  assign tick = en && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (reload) begin
      count <= '0;
    end else if (tick) begin
      count <= 8'(DIV - 1);
    end else if (en) begin
      count <= count - 8'd1;
    end
  end

endmodule

// File: rtl/chirp_phase_gen.sv
// Linear-FM chirp phase-word generator feeding the sine ROM.
// Optional CHIRP_DITHER_EN adds LFSR dither below the emitted phase field.
module chirp_phase_gen
  import chirp_pkg::*;
#(
  parameter int unsigned PHASE_W    = 48,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned STROBE_DIV = 7
) (
  input logic             clk,
  input logic             rst_n,
  chirp_phase_gen_if.slave bus
);

  state_t             state;
  sweep_mode_t        mode;
  logic [PHASE_W-1:0] start_r;
  logic [PHASE_W-1:0] stop_r;
  logic [PHASE_W-1:0] rate_r;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] freq;
  logic [OUT_W-1:0]   emit;

  logic start_bad;
  logic go;
  logic tick;
  logic sample;

  // Saturating steps computed one bit wider so a carry/borrow clamps.
  function automatic logic [PHASE_W-1:0] step_up(
    input logic [PHASE_W-1:0] base,
    input logic [PHASE_W-1:0] inc,
    input logic [PHASE_W-1:0] hi
  );
    logic [PHASE_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return (sum[PHASE_W] || (sum[PHASE_W-1:0] > hi)) ? hi : sum[PHASE_W-1:0];
  endfunction

  function automatic logic [PHASE_W-1:0] step_down(
    input logic [PHASE_W-1:0] base,
    input logic [PHASE_W-1:0] dec,
    input logic [PHASE_W-1:0] lo
  );
    logic [PHASE_W:0] diff;
    diff = {1'b0, base} - {1'b0, dec};
    return (diff[PHASE_W] || (diff[PHASE_W-1:0] < lo)) ? lo : diff[PHASE_W-1:0];
  endfunction

  assign start_bad = bus.cfg_start_freq > bus.cfg_stop_freq;
  assign go        = bus.cmd_start && !bus.cmd_stop && !start_bad;
  // Stop and an accepted start both pre-empt a strobe landing in the same cycle.
  assign sample    = tick && !bus.cmd_stop && !go;

  strobe_div #(
    .DIV (STROBE_DIV)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state != IDLE),
    .reload (go),
    .tick   (tick)
  );

`ifdef CHIRP_DITHER_EN
  localparam int unsigned DITH_W  = ((PHASE_W - OUT_W) < 16) ? (PHASE_W - OUT_W) : 16;
  localparam int unsigned DITH_SH = PHASE_W - OUT_W - DITH_W;

  logic [15:0]        lfsr;
  logic [PHASE_W-1:0] dithered;

  // Dither sits just below the emitted field; carry into it wraps freely.
  assign dithered = phase + (PHASE_W'(lfsr[DITH_W-1:0]) << DITH_SH);
  assign emit     = dithered[PHASE_W-1 -: OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (sample) begin
      lfsr <= lfsr_next(lfsr);
    end
  end
`else
  assign emit = phase[PHASE_W-1 -: OUT_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mode            <= MODE_SINGLE;
      start_r         <= '0;
      stop_r          <= '0;
      rate_r          <= '0;
      phase           <= '0;
      freq            <= '0;
      bus.busy        <= 1'b0;
      bus.phase_valid <= 1'b0;
      bus.phase_out   <= '0;
      bus.freq_out    <= '0;
      bus.sweep_wrap  <= 1'b0;
      bus.done        <= 1'b0;
      bus.cfg_err     <= 1'b0;
    end else begin
      bus.phase_valid <= 1'b0;
      bus.sweep_wrap  <= 1'b0;
      bus.done        <= 1'b0;
      bus.cfg_err     <= bus.cmd_start && !bus.cmd_stop && start_bad;

      if (bus.cmd_stop) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
      end else if (go) begin
        mode     <= decode_mode(bus.cfg_mode);
        start_r  <= bus.cfg_start_freq;
        stop_r   <= bus.cfg_stop_freq;
        rate_r   <= bus.cfg_rate;
        phase    <= '0;
        freq     <= bus.cfg_start_freq;
        state    <= SWEEP_UP;
        bus.busy <= 1'b1;
      end else if (sample) begin
        bus.phase_valid <= 1'b1;
        bus.phase_out   <= emit;
        bus.freq_out    <= freq;
        phase           <= phase + freq;

        case (state)
          SWEEP_UP: begin
            if (freq == stop_r) begin
              case (mode)
                MODE_REPEAT: begin
                  freq           <= start_r;
                  bus.sweep_wrap <= 1'b1;
                end
                MODE_TRIANGLE: begin
                  freq           <= step_down(stop_r, rate_r, start_r);
                  state          <= SWEEP_DOWN;
                  bus.sweep_wrap <= 1'b1;
                end
                default: begin
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
                end
              endcase
            end else begin
              freq <= step_up(freq, rate_r, stop_r);
            end
          end
          SWEEP_DOWN: begin
            if (freq == start_r) begin
              freq  <= step_up(start_r, rate_r, stop_r);
              state <= SWEEP_UP;
            end else begin
              freq <= step_down(freq, rate_r, start_r);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chirp_phase_gen.sv
// Self-checking bench for chirp_phase_gen: directed and random sweeps against
// a sample-list reference model, plus divider latency and control checks.
module tb_chirp_phase_gen;

  localparam int unsigned PW = 16;
  localparam int unsigned OW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  chirp_phase_gen_if #(.PHASE_W(PW), .OUT_W(OW)) bus1 ();
  chirp_phase_gen_if #(.PHASE_W(PW), .OUT_W(OW)) bus7 ();

  chirp_phase_gen #(.PHASE_W(PW), .OUT_W(OW), .STROBE_DIV(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  chirp_phase_gen #(.PHASE_W(PW), .OUT_W(OW), .STROBE_DIV(7)) dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus7)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus1.busy),        32'd0);
    check({tag, "_valid"}, 32'(bus1.phase_valid), 32'd0);
    check({tag, "_phase"}, 32'(bus1.phase_out),   32'd0);
    check({tag, "_freq"},  32'(bus1.freq_out),    32'd0);
    check({tag, "_wrap"},  32'(bus1.sweep_wrap),  32'd0);
    check({tag, "_done"},  32'(bus1.done),        32'd0);
    check({tag, "_err"},   32'(bus1.cfg_err),     32'd0);
  endtask

  // Reference: list the samples a sweep should emit, straight from the sweep rules.
  task automatic sweep(input string tag, input int s, input int e, input int r,
                       input int m, input int nmax);
    int ph = 0;
    int f  = s;
    bit up = 1'b1;
    bit fin = 1'b0;
    bit updown;
    int k = 0;
    int cyc = 0;
    int n;
    int eph[$];
    int ef[$];
    int ew[$];
    int ed[$];
    updown = (m == 1) || (m == 2);
    while (!fin && eph.size() < nmax) begin
      eph.push_back(ph / 256);
      ef.push_back(f);
      ew.push_back(int'(updown && up && f == e));
      ed.push_back(int'(!updown && f == e));
      ph = (ph + f) % 65536;
      if (up) begin
        if (f == e) begin
          if (m == 1) f = s;
          else if (m == 2) begin
            f  = (e - r < s) ? s : e - r;
            up = 1'b0;
          end else fin = 1'b1;
        end else f = (f + r > e) ? e : f + r;
      end else begin
        if (f == s) begin
          f  = (s + r > e) ? e : s + r;
          up = 1'b1;
        end else f = (f - r < s) ? s : f - r;
      end
    end
    n = eph.size();

    bus1.cfg_start_freq = PW'(s);
    bus1.cfg_stop_freq  = PW'(e);
    bus1.cfg_rate       = PW'(r);
    bus1.cfg_mode       = 2'(m);
    bus1.cmd_start      = 1'b1;
    @(negedge clk);
    bus1.cmd_start      = 1'b0;
    // Configuration must be ignored once the sweep is running.
    bus1.cfg_start_freq = PW'($urandom);
    bus1.cfg_stop_freq  = PW'($urandom);
    bus1.cfg_rate       = PW'($urandom);
    bus1.cfg_mode       = 2'($urandom);
    check($sformatf("%s_nolat", tag), 32'(bus1.phase_valid), 32'd0);

    while (k < n && cyc < 2 * nmax + 10) begin
      @(negedge clk);
      cyc++;
      if (bus1.phase_valid) begin
        check($sformatf("%s_ph%0d", tag, k),   32'(bus1.phase_out),  eph[k]);
        check($sformatf("%s_fr%0d", tag, k),   32'(bus1.freq_out),   ef[k]);
        check($sformatf("%s_wr%0d", tag, k),   32'(bus1.sweep_wrap), ew[k]);
        check($sformatf("%s_dn%0d", tag, k),   32'(bus1.done),       ed[k]);
        check($sformatf("%s_busy%0d", tag, k), 32'(bus1.busy),       32'(ed[k] == 0));
        k++;
      end
    end
    check({tag, "_count"}, k, n);

    if (n > 0 && ed[n-1] != 0) begin
      @(negedge clk);
    end else begin
      bus1.cmd_stop = 1'b1;
      @(negedge clk);
      bus1.cmd_stop = 1'b0;
    end
    check({tag, "_endvalid"}, 32'(bus1.phase_valid), 32'd0);
    check({tag, "_endbusy"},  32'(bus1.busy),        32'd0);
    @(negedge clk);
    check({tag, "_quiet"}, 32'(bus1.phase_valid), 32'd0);
  endtask

  initial begin
    int s;
    int e;
    int r;
    int m;
    bit exp_v;

    bus1.cfg_start_freq = '0;
    bus1.cfg_stop_freq  = '0;
    bus1.cfg_rate       = '0;
    bus1.cfg_mode       = '0;
    bus1.cmd_start      = 1'b0;
    bus1.cmd_stop       = 1'b0;
    bus7.cfg_start_freq = '0;
    bus7.cfg_stop_freq  = '0;
    bus7.cfg_rate       = '0;
    bus7.cfg_mode       = '0;
    bus7.cmd_start      = 1'b0;
    bus7.cmd_stop       = 1'b0;

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    sweep("single",   16'h0100, 16'h0400, 16'h0100, 0, 40);
    sweep("clamp",    16'h0100, 16'h0350, 16'h0100, 0, 40);
    sweep("carry",    16'hFF00, 16'hFFFF, 16'h0200, 0, 40);
    sweep("triangle", 16'h0100, 16'h0300, 16'h0100, 2, 7);
    sweep("sawtooth", 16'h0100, 16'h0300, 16'h0100, 1, 8);
    sweep("onesamp",  16'h1234, 16'h1234, 16'h0010, 0, 40);
    sweep("mode3",    16'h0200, 16'h0500, 16'h0180, 3, 40);
    sweep("rate0",    16'h0100, 16'h0200, 16'h0000, 0, 6);
    sweep("tridown",  16'h0100, 16'hF000, 16'h7000, 2, 9);

    for (int i = 0; i < 12; i++) begin
      s = int'($urandom_range(0, 16'hE000));
      e = s + int'($urandom_range(1, 16'hFFFF - s));
      r = int'($urandom_range(0, 16'h3000));
      m = int'($urandom_range(0, 3));
      sweep($sformatf("rnd%0d", i), s, e, r, m, 20);
    end

    // start and stop together: stop wins
    bus1.cfg_start_freq = 16'h0100;
    bus1.cfg_stop_freq  = 16'h0400;
    bus1.cfg_rate       = 16'h0100;
    bus1.cfg_mode       = 2'd0;
    bus1.cmd_start      = 1'b1;
    bus1.cmd_stop       = 1'b1;
    @(negedge clk);
    bus1.cmd_start = 1'b0;
    bus1.cmd_stop  = 1'b0;
    check("both_busy", 32'(bus1.busy), 32'd0);
    @(negedge clk);
    check("both_valid", 32'(bus1.phase_valid), 32'd0);

    // start > stop is rejected
    bus1.cfg_start_freq = 16'h0500;
    bus1.cfg_stop_freq  = 16'h0400;
    bus1.cmd_start      = 1'b1;
    @(negedge clk);
    bus1.cmd_start = 1'b0;
    check("err_pulse", 32'(bus1.cfg_err), 32'd1);
    check("err_busy",  32'(bus1.busy),    32'd0);
    @(negedge clk);
    check("err_clear", 32'(bus1.cfg_err),     32'd0);
    check("err_valid", 32'(bus1.phase_valid), 32'd0);

    // divider: first sample two cycles after the command, then every 7 cycles
    bus7.cfg_start_freq = 16'h0100;
    bus7.cfg_stop_freq  = 16'h4000;
    bus7.cfg_rate       = 16'h0100;
    bus7.cfg_mode       = 2'd0;
    bus7.cmd_start      = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      bus7.cmd_start = 1'b0;
      exp_v = (t >= 2) && ((t - 2) % 7 == 0);
      check($sformatf("div7_t%0d", t), 32'(bus7.phase_valid), 32'(exp_v));
    end
    bus7.cmd_stop = 1'b1;
    @(negedge clk);
    bus7.cmd_stop = 1'b0;
    check("div7_stopbusy", 32'(bus7.busy), 32'd0);

    // asynchronous reset in the middle of a sweep
    bus1.cfg_start_freq = 16'h0100;
    bus1.cfg_stop_freq  = 16'h0800;
    bus1.cfg_rate       = 16'h0100;
    bus1.cfg_mode       = 2'd1;
    bus1.cmd_start      = 1'b1;
    @(negedge clk);
    bus1.cmd_start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_valid", 32'(bus1.phase_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(bus1.phase_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
